// File: rtl/id_ex_stage_pkg.sv
// Shared definitions for the ID/EX stage: ALU op codes, MIPS opcode/funct values
// and the decoded-control record produced by the ALU control decoder.
package id_ex_stage_pkg;

    typedef enum logic [3:0] {
        ALU_SLL = 4'd0,
        ALU_SRL = 4'd1,
        ALU_SRA = 4'd2,
        ALU_ADD = 4'd3,
        ALU_SUB = 4'd4,
        ALU_AND = 4'd5,
        ALU_OR  = 4'd6,
        ALU_XOR = 4'd7,
        ALU_NOR = 4'd8,
        ALU_SLT = 4'd9
    } alu_op_e;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_SRA  = 6'h03;
    localparam logic [5:0] FN_SLLV = 6'h04;
    localparam logic [5:0] FN_SRLV = 6'h06;
    localparam logic [5:0] FN_SRAV = 6'h07;
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26;
    localparam logic [5:0] FN_NOR  = 6'h27;
    localparam logic [5:0] FN_SLT  = 6'h2A;

    // Encoding 0 of each select is the plain rs/rt path so an all-zero bubble reads register 0.
    typedef enum logic [1:0] {OP1_RS, OP1_RT, OP1_IMM} op1_sel_e;
    typedef enum logic [2:0] {OP2_RT, OP2_SHAMT, OP2_RS5, OP2_IMM, OP2_SIXTEEN} op2_sel_e;
    typedef enum logic [1:0] {DEST_NONE, DEST_RD, DEST_RT} dest_sel_e;

    typedef struct packed {
        alu_op_e   alu_op;
        op1_sel_e  op1_sel;
        op2_sel_e  op2_sel;
        logic      imm_sext;
        dest_sel_e dest_sel;
        logic      reg_write;
        logic      mem_read;
        logic      mem_write;
        logic      mem_to_reg;
        logic      uses_rt;
    } ctrl_t;

    localparam ctrl_t CTRL_NOP = '{alu_op: ALU_ADD, op1_sel: OP1_RS, op2_sel: OP2_RT,
                                   imm_sext: 1'b0, dest_sel: DEST_NONE, reg_write: 1'b0,
                                   mem_read: 1'b0, mem_write: 1'b0, mem_to_reg: 1'b0,
                                   uses_rt: 1'b0};

    function automatic ctrl_t r_ctrl(input alu_op_e op, input op1_sel_e s1, input op2_sel_e s2);
        ctrl_t c;
        c           = CTRL_NOP;
        c.alu_op    = op;
        c.op1_sel   = s1;
        c.op2_sel   = s2;
        c.dest_sel  = DEST_RD;
        c.reg_write = 1'b1;
        c.uses_rt   = 1'b1;
        return c;
    endfunction

    function automatic ctrl_t i_ctrl(input alu_op_e op, input op1_sel_e s1, input op2_sel_e s2,
                                     input logic sext);
        ctrl_t c;
        c           = CTRL_NOP;
        c.alu_op    = op;
        c.op1_sel   = s1;
        c.op2_sel   = s2;
        c.imm_sext  = sext;
        c.dest_sel  = DEST_RT;
        c.reg_write = 1'b1;
        return c;
    endfunction

endpackage

// File: rtl/id_ex_stage_if.sv
// ID/EX bus: decoded ID fields and forwarding sources in, ALU operands and EX controls out.
interface id_ex_stage_if #(parameter int N = 32);
    logic                id_valid;
    logic [5:0]          id_opcode;
    logic [5:0]          id_funct;
    logic [4:0]          id_shamt;
    logic [4:0]          id_rs;
    logic [4:0]          id_rt;
    logic [4:0]          id_rd;
    logic [N-1:0]        id_rs_data;
    logic [N-1:0]        id_rt_data;
    logic [15:0]         id_imm;
    logic                stall_i;
    logic                flush_i;
    logic                exmem_reg_write;
    logic [4:0]          exmem_rd;
    logic [N-1:0]        exmem_result;
    logic                memwb_reg_write;
    logic [4:0]          memwb_rd;
    logic [N-1:0]        memwb_result;
    logic                load_use_o;
    logic                ex_valid;
    logic [3:0]          alu_op_code;
    logic signed [N-1:0] alu_operand1;
    logic signed [N-1:0] alu_operand2;
    logic [4:0]          ex_dest;
    logic                ex_reg_write;
    logic                ex_mem_read;
    logic                ex_mem_write;
    logic                ex_mem_to_reg;
    logic [N-1:0]        ex_store_data;

    modport master (
        output id_valid, id_opcode, id_funct, id_shamt, id_rs, id_rt, id_rd,
               id_rs_data, id_rt_data, id_imm, stall_i, flush_i,
               exmem_reg_write, exmem_rd, exmem_result,
               memwb_reg_write, memwb_rd, memwb_result,
        input  load_use_o, ex_valid, alu_op_code, alu_operand1, alu_operand2, ex_dest,
               ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_store_data
    );

    modport slave (
        input  id_valid, id_opcode, id_funct, id_shamt, id_rs, id_rt, id_rd,
               id_rs_data, id_rt_data, id_imm, stall_i, flush_i,
               exmem_reg_write, exmem_rd, exmem_result,
               memwb_reg_write, memwb_rd, memwb_result,
        output load_use_o, ex_valid, alu_op_code, alu_operand1, alu_operand2, ex_dest,
               ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_store_data
    );
endinterface

// File: rtl/id_ex_stage_alu_control.sv
// Combinational decoder: opcode/funct to ALU op, operand selects, immediate extension
// and EX/MEM control bits. Unknown encodings decode as a NOP (ADD, no side effects).
module id_ex_stage_alu_control
    import id_ex_stage_pkg::*;
(
    input  logic [5:0] opcode_i,
    input  logic [5:0] funct_i,
    output ctrl_t      ctrl_o
);

    always_comb begin
        ctrl_o = CTRL_NOP;
        if (opcode_i == OP_RTYPE) begin
            case (funct_i)
                FN_SLL:           ctrl_o = r_ctrl(ALU_SLL, OP1_RT, OP2_SHAMT);
                FN_SRL:           ctrl_o = r_ctrl(ALU_SRL, OP1_RT, OP2_SHAMT);
                FN_SRA:           ctrl_o = r_ctrl(ALU_SRA, OP1_RT, OP2_SHAMT);
                FN_SLLV:          ctrl_o = r_ctrl(ALU_SLL, OP1_RT, OP2_RS5);
                FN_SRLV:          ctrl_o = r_ctrl(ALU_SRL, OP1_RT, OP2_RS5);
                FN_SRAV:          ctrl_o = r_ctrl(ALU_SRA, OP1_RT, OP2_RS5);
                FN_ADD, FN_ADDU:  ctrl_o = r_ctrl(ALU_ADD, OP1_RS, OP2_RT);
                FN_SUB, FN_SUBU:  ctrl_o = r_ctrl(ALU_SUB, OP1_RS, OP2_RT);
                FN_AND:           ctrl_o = r_ctrl(ALU_AND, OP1_RS, OP2_RT);
                FN_OR:            ctrl_o = r_ctrl(ALU_OR,  OP1_RS, OP2_RT);
                FN_XOR:           ctrl_o = r_ctrl(ALU_XOR, OP1_RS, OP2_RT);
                FN_NOR:           ctrl_o = r_ctrl(ALU_NOR, OP1_RS, OP2_RT);
                FN_SLT:           ctrl_o = r_ctrl(ALU_SLT, OP1_RS, OP2_RT);
                default:          ctrl_o = CTRL_NOP;
            endcase
        end else begin
            case (opcode_i)
                OP_ADDI, OP_ADDIU: ctrl_o = i_ctrl(ALU_ADD, OP1_RS, OP2_IMM, 1'b1);
                OP_SLTI:           ctrl_o = i_ctrl(ALU_SLT, OP1_RS, OP2_IMM, 1'b1);
                OP_ANDI:           ctrl_o = i_ctrl(ALU_AND, OP1_RS, OP2_IMM, 1'b0);
                OP_ORI:            ctrl_o = i_ctrl(ALU_OR,  OP1_RS, OP2_IMM, 1'b0);
                OP_XORI:           ctrl_o = i_ctrl(ALU_XOR, OP1_RS, OP2_IMM, 1'b0);
                OP_LUI:            ctrl_o = i_ctrl(ALU_SLL, OP1_IMM, OP2_SIXTEEN, 1'b0);
                OP_LW: begin
                    ctrl_o            = i_ctrl(ALU_ADD, OP1_RS, OP2_IMM, 1'b1);
                    ctrl_o.mem_read   = 1'b1;
                    ctrl_o.mem_to_reg = 1'b1;
                end
                OP_SW: begin
                    // Stores read rt for data and write no register.
                    ctrl_o           = i_ctrl(ALU_ADD, OP1_RS, OP2_IMM, 1'b1);
                    ctrl_o.dest_sel  = DEST_NONE;
                    ctrl_o.reg_write = 1'b0;
                    ctrl_o.mem_write = 1'b1;
                    ctrl_o.uses_rt   = 1'b1;
                end
                default:           ctrl_o = CTRL_NOP;
            endcase
        end
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection and EX/MEM, MEM/WB operand
// forwarding; ALU operands are muxed combinationally from the registered fields.
module id_ex_stage
    import id_ex_stage_pkg::*;
#(
    parameter int N = 32
) (
    input logic          clk,
    input logic          rst_n,
    id_ex_stage_if.slave bus
);

    typedef struct packed {
        logic         vld;
        alu_op_e      op;
        op1_sel_e     op1_sel;
        op2_sel_e     op2_sel;
        logic [N-1:0] imm;
        logic [4:0]   shamt;
        logic [4:0]   rs;
        logic [4:0]   rt;
        logic [4:0]   dest;
        logic [N-1:0] rs_data;
        logic [N-1:0] rt_data;
        logic         reg_write;
        logic         mem_read;
        logic         mem_write;
        logic         mem_to_reg;
    } stage_t;

    stage_t       stage_d, stage_q;
    ctrl_t        id_ctrl;
    logic [4:0]   id_dest;
    logic [N-1:0] imm_ext;
    logic         load_use;
    logic [N-1:0] fwd_rs, fwd_rt, op1, op2;

    function automatic logic [N-1:0] fwd(
        input logic [4:0] r,   input logic [N-1:0] rdata,
        input logic exw,       input logic [4:0] exrd, input logic [N-1:0] exres,
        input logic wbw,       input logic [4:0] wbrd, input logic [N-1:0] wbres
    );
        if (r == 5'd0)                 return '0;
        else if (exw && (exrd == r))   return exres;
        else if (wbw && (wbrd == r))   return wbres;
        else                           return rdata;
    endfunction

    id_ex_stage_alu_control u_alu_control (
        .opcode_i (bus.id_opcode),
        .funct_i  (bus.id_funct),
        .ctrl_o   (id_ctrl)
    );

    always_comb begin
        case (id_ctrl.dest_sel)
            DEST_RD: id_dest = bus.id_rd;
            DEST_RT: id_dest = bus.id_rt;
            default: id_dest = 5'd0;
        endcase
        imm_ext = id_ctrl.imm_sext ? {{(N-16){bus.id_imm[15]}}, bus.id_imm}
                                   : {{(N-16){1'b0}}, bus.id_imm};
    end

    assign load_use = bus.id_valid & stage_q.vld & stage_q.mem_read & (stage_q.dest != 5'd0) &
                      ((stage_q.dest == bus.id_rs) |
                       ((stage_q.dest == bus.id_rt) & id_ctrl.uses_rt));

    // ---- ID -> EX register: flush > stall > load-use bubble > capture ----
    always_comb begin
        stage_d = stage_q;
        if (bus.flush_i) begin
            stage_d = '0;
        end else if (bus.stall_i) begin
            stage_d = stage_q;
        end else if (load_use) begin
            stage_d = '0;
        end else begin
            stage_d.vld        = bus.id_valid;
            stage_d.op         = id_ctrl.alu_op;
            stage_d.op1_sel    = id_ctrl.op1_sel;
            stage_d.op2_sel    = id_ctrl.op2_sel;
            stage_d.imm        = imm_ext;
            stage_d.shamt      = bus.id_shamt;
            stage_d.rs         = bus.id_rs;
            stage_d.rt         = bus.id_rt;
            stage_d.dest       = id_dest;
            stage_d.rs_data    = bus.id_rs_data;
            stage_d.rt_data    = bus.id_rt_data;
            stage_d.reg_write  = bus.id_valid & id_ctrl.reg_write & (id_dest != 5'd0);
            stage_d.mem_read   = bus.id_valid & id_ctrl.mem_read;
            stage_d.mem_write  = bus.id_valid & id_ctrl.mem_write;
            stage_d.mem_to_reg = bus.id_valid & id_ctrl.mem_to_reg;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) stage_q <= '0;
        else        stage_q <= stage_d;
    end

    // ---- EX: forwarding and operand muxes ----
    always_comb begin
        fwd_rs = fwd(stage_q.rs, stage_q.rs_data,
                     bus.exmem_reg_write, bus.exmem_rd, bus.exmem_result,
                     bus.memwb_reg_write, bus.memwb_rd, bus.memwb_result);
        fwd_rt = fwd(stage_q.rt, stage_q.rt_data,
                     bus.exmem_reg_write, bus.exmem_rd, bus.exmem_result,
                     bus.memwb_reg_write, bus.memwb_rd, bus.memwb_result);
    end

    always_comb begin
        case (stage_q.op1_sel)
            OP1_RT:  op1 = fwd_rt;
            OP1_IMM: op1 = stage_q.imm;
            default: op1 = fwd_rs;
        endcase
        case (stage_q.op2_sel)
            OP2_SHAMT:   op2 = N'(stage_q.shamt);
            OP2_RS5:     op2 = N'(fwd_rs[4:0]);
            OP2_IMM:     op2 = stage_q.imm;
            OP2_SIXTEEN: op2 = N'(16);
            default:     op2 = fwd_rt;
        endcase
    end

    assign bus.load_use_o    = load_use;
    assign bus.ex_valid      = stage_q.vld;
    assign bus.alu_op_code   = stage_q.op;
    assign bus.alu_operand1  = op1;
    assign bus.alu_operand2  = op2;
    assign bus.ex_dest       = stage_q.dest;
    assign bus.ex_reg_write  = stage_q.reg_write;
    assign bus.ex_mem_read   = stage_q.mem_read;
    assign bus.ex_mem_write  = stage_q.mem_write;
    assign bus.ex_mem_to_reg = stage_q.mem_to_reg;
    assign bus.ex_store_data = fwd_rt;

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed scenarios plus randomized traffic
// compared against an instruction-level reference model.
module tb_id_ex_stage;

    localparam int N = 32;

    logic clk = 1'b0;
    logic rst_n;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    id_ex_stage_if #(.N(N)) bus ();

    id_ex_stage #(.N(N)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic        valid;
        logic [5:0]  opcode;
        logic [5:0]  funct;
        logic [4:0]  shamt;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [31:0] rs_data;
        logic [31:0] rt_data;
        logic [15:0] imm;
    } instr_t;

    typedef struct {
        logic        valid;
        logic [3:0]  op;
        logic [31:0] op1;
        logic [31:0] op2;
        logic [31:0] store;
        logic [4:0]  dest;
        logic        rw, mr, mw, m2r;
    } exp_t;

    // {opcode, funct}: every legal instruction plus three undefined encodings.
    localparam logic [11:0] OPS [24] = '{
        {6'h00, 6'h00}, {6'h00, 6'h02}, {6'h00, 6'h03}, {6'h00, 6'h04}, {6'h00, 6'h06},
        {6'h00, 6'h07}, {6'h00, 6'h20}, {6'h00, 6'h21}, {6'h00, 6'h22}, {6'h00, 6'h23},
        {6'h00, 6'h24}, {6'h00, 6'h25}, {6'h00, 6'h26}, {6'h00, 6'h27}, {6'h00, 6'h2A},
        {6'h08, 6'h11}, {6'h09, 6'h00}, {6'h0A, 6'h00}, {6'h0C, 6'h00}, {6'h0D, 6'h00},
        {6'h0E, 6'h00}, {6'h0F, 6'h00}, {6'h23, 6'h00}, {6'h2B, 6'h00}
    };
    localparam logic [11:0] BAD_OPS [3] = '{{6'h00, 6'h3F}, {6'h3F, 6'h00}, {6'h02, 6'h20}};

    instr_t ex_model;

    function automatic instr_t mk(input logic v, input logic [5:0] opc, input logic [5:0] fn,
                                  input logic [4:0] sh, input logic [4:0] rs, input logic [4:0] rt,
                                  input logic [4:0] rd, input logic [31:0] rsd,
                                  input logic [31:0] rtd, input logic [15:0] imm);
        instr_t i;
        i.valid = v;   i.opcode = opc; i.funct = fn; i.shamt = sh;
        i.rs = rs;     i.rt = rt;      i.rd = rd;
        i.rs_data = rsd; i.rt_data = rtd; i.imm = imm;
        return i;
    endfunction

    task automatic drive(input instr_t i);
        bus.id_valid   = i.valid;
        bus.id_opcode  = i.opcode;
        bus.id_funct   = i.funct;
        bus.id_shamt   = i.shamt;
        bus.id_rs      = i.rs;
        bus.id_rt      = i.rt;
        bus.id_rd      = i.rd;
        bus.id_rs_data = i.rs_data;
        bus.id_rt_data = i.rt_data;
        bus.id_imm     = i.imm;
    endtask

    task automatic idle();
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        bus.stall_i = 0; bus.flush_i = 0;
        bus.exmem_reg_write = 0; bus.exmem_rd = 0; bus.exmem_result = 0;
        bus.memwb_reg_write = 0; bus.memwb_rd = 0; bus.memwb_result = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- reference model ----------------
    function automatic logic [31:0] m_fwd(input logic [4:0] r, input logic [31:0] d);
        if (r == 0) return 32'd0;
        if (bus.exmem_reg_write && bus.exmem_rd == r) return bus.exmem_result;
        if (bus.memwb_reg_write && bus.memwb_rd == r) return bus.memwb_result;
        return d;
    endfunction

    function automatic logic reads_rt(input logic [5:0] opc, input logic [5:0] fn);
        if (opc == 6'h2B) return 1'b1;
        if (opc != 6'h00) return 1'b0;
        return fn inside {6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h20, 6'h21,
                          6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A};
    endfunction

    function automatic exp_t model(input instr_t e);
        exp_t x;
        logic [31:0] a, b, sx, zx;
        a  = m_fwd(e.rs, e.rs_data);
        b  = m_fwd(e.rt, e.rt_data);
        sx = {{16{e.imm[15]}}, e.imm};
        zx = {16'h0, e.imm};
        x.valid = e.valid; x.op = 4'd3; x.op1 = a; x.op2 = b; x.store = b;
        x.dest = 0; x.rw = 0; x.mr = 0; x.mw = 0; x.m2r = 0;
        if (e.opcode == 6'h00) begin
            x.dest = e.rd; x.rw = 1;
            case (e.funct)
                6'h00: begin x.op = 0; x.op1 = b; x.op2 = {27'd0, e.shamt}; end
                6'h02: begin x.op = 1; x.op1 = b; x.op2 = {27'd0, e.shamt}; end
                6'h03: begin x.op = 2; x.op1 = b; x.op2 = {27'd0, e.shamt}; end
                6'h04: begin x.op = 0; x.op1 = b; x.op2 = {27'd0, a[4:0]}; end
                6'h06: begin x.op = 1; x.op1 = b; x.op2 = {27'd0, a[4:0]}; end
                6'h07: begin x.op = 2; x.op1 = b; x.op2 = {27'd0, a[4:0]}; end
                6'h20, 6'h21: x.op = 3;
                6'h22, 6'h23: x.op = 4;
                6'h24: x.op = 5;
                6'h25: x.op = 6;
                6'h26: x.op = 7;
                6'h27: x.op = 8;
                6'h2A: x.op = 9;
                default: begin x.dest = 0; x.rw = 0; end
            endcase
        end else begin
            x.dest = e.rt; x.rw = 1;
            case (e.opcode)
                6'h08, 6'h09: x.op2 = sx;
                6'h0A: begin x.op = 9; x.op2 = sx; end
                6'h0C: begin x.op = 5; x.op2 = zx; end
                6'h0D: begin x.op = 6; x.op2 = zx; end
                6'h0E: begin x.op = 7; x.op2 = zx; end
                6'h0F: begin x.op = 0; x.op1 = zx; x.op2 = 32'd16; end
                6'h23: begin x.op2 = sx; x.mr = 1; x.m2r = 1; end
                6'h2B: begin x.op2 = sx; x.dest = 0; x.rw = 0; x.mw = 1; end
                default: begin x.dest = 0; x.rw = 0; end
            endcase
        end
        if (x.dest == 0) x.rw = 0;
        if (!e.valid) begin x.rw = 0; x.mr = 0; x.mw = 0; x.m2r = 0; end
        return x;
    endfunction

    function automatic logic m_load_use();
        return ex_model.valid && ex_model.opcode == 6'h23 && ex_model.rt != 0 && bus.id_valid &&
               (ex_model.rt == bus.id_rs ||
                (ex_model.rt == bus.id_rt && reads_rt(bus.id_opcode, bus.id_funct)));
    endfunction

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst_n = 0;
        idle();
        tick(); tick();
        checks++;
        if ({bus.ex_valid, bus.alu_op_code, bus.ex_dest, bus.ex_reg_write, bus.ex_mem_read,
             bus.ex_mem_write, bus.ex_mem_to_reg, bus.load_use_o} !== 15'd0) begin
            failures++;
            $display("FAIL reset_ctrl got valid=%b op=%0d dest=%0d rw=%b mr=%b mw=%b m2r=%b lu=%b expected all 0",
                     bus.ex_valid, bus.alu_op_code, bus.ex_dest, bus.ex_reg_write,
                     bus.ex_mem_read, bus.ex_mem_write, bus.ex_mem_to_reg, bus.load_use_o);
        end
        checks++;
        if ({bus.alu_operand1, bus.alu_operand2, bus.ex_store_data} !== 96'd0) begin
            failures++;
            $display("FAIL reset_data got op1=%h op2=%h store=%h expected 0",
                     bus.alu_operand1, bus.alu_operand2, bus.ex_store_data);
        end
        rst_n = 1;
        tick();
    endtask

    task automatic test_add();
        drive(mk(1, 6'h00, 6'h20, 0, 1, 2, 3, 32'd5, 32'd7, 0));
        tick();
        idle();
        #1;
        checks++;
        if ({bus.ex_valid, bus.alu_op_code, bus.ex_dest, bus.ex_reg_write} !== {1'b1, 4'd3, 5'd3, 1'b1}) begin
            failures++;
            $display("FAIL add_ctrl got valid=%b op=%0d dest=%0d rw=%b expected 1/3/3/1",
                     bus.ex_valid, bus.alu_op_code, bus.ex_dest, bus.ex_reg_write);
        end
        checks++;
        if (bus.alu_operand1 !== 32'd5 || bus.alu_operand2 !== 32'd7) begin
            failures++;
            $display("FAIL add_operands got op1=%0d op2=%0d expected 5/7", bus.alu_operand1, bus.alu_operand2);
        end
    endtask

    task automatic test_forward();
        drive(mk(1, 6'h00, 6'h20, 0, 1, 2, 3, 32'd1, 32'd2, 0));
        tick();
        idle();
        bus.exmem_reg_write = 1; bus.exmem_rd = 1; bus.exmem_result = 32'd100;
        bus.memwb_reg_write = 1; bus.memwb_rd = 1; bus.memwb_result = 32'd50;
        #1;
        checks++;
        if (bus.alu_operand1 !== 32'd100) begin
            failures++;
            $display("FAIL fwd_exmem_wins got op1=%0d expected 100", bus.alu_operand1);
        end
        bus.exmem_reg_write = 0;
        bus.memwb_rd = 2; bus.memwb_result = 32'd55;
        bus.exmem_reg_write = 1; bus.exmem_rd = 5;
        #1;
        checks++;
        if (bus.alu_operand1 !== 32'd1 || bus.alu_operand2 !== 32'd55 || bus.ex_store_data !== 32'd55) begin
            failures++;
            $display("FAIL fwd_memwb_rt got op1=%0d op2=%0d store=%0d expected 1/55/55",
                     bus.alu_operand1, bus.alu_operand2, bus.ex_store_data);
        end
        idle();
        drive(mk(1, 6'h00, 6'h20, 0, 0, 2, 3, 32'd77, 32'd2, 0));
        tick();
        idle();
        bus.exmem_reg_write = 1; bus.exmem_rd = 0; bus.exmem_result = 32'd100;
        bus.memwb_reg_write = 1; bus.memwb_rd = 0; bus.memwb_result = 32'd50;
        #1;
        checks++;
        if (bus.alu_operand1 !== 32'd0) begin
            failures++;
            $display("FAIL fwd_r0 got op1=%0d expected 0", bus.alu_operand1);
        end
        idle();
    endtask

    task automatic test_load_use();
        drive(mk(1, 6'h23, 6'h00, 0, 1, 4, 0, 32'd10, 32'd0, 16'd0));
        tick();
        drive(mk(1, 6'h00, 6'h20, 0, 4, 4, 5, 32'd9, 32'd9, 0));
        #1;
        checks++;
        if (bus.load_use_o !== 1'b1 || bus.ex_mem_read !== 1'b1) begin
            failures++;
            $display("FAIL lu_detect got lu=%b mr=%b expected 1/1", bus.load_use_o, bus.ex_mem_read);
        end
        tick();
        checks++;
        if (bus.ex_valid !== 1'b0 || bus.load_use_o !== 1'b0 || bus.ex_reg_write !== 1'b0) begin
            failures++;
            $display("FAIL lu_bubble got valid=%b lu=%b rw=%b expected 0/0/0",
                     bus.ex_valid, bus.load_use_o, bus.ex_reg_write);
        end
        tick();
        idle();
        #1;
        checks++;
        if ({bus.ex_valid, bus.alu_op_code, bus.ex_dest} !== {1'b1, 4'd3, 5'd5}) begin
            failures++;
            $display("FAIL lu_reissue got valid=%b op=%0d dest=%0d expected 1/3/5",
                     bus.ex_valid, bus.alu_op_code, bus.ex_dest);
        end
    endtask

    task automatic test_shift_lui();
        drive(mk(1, 6'h00, 6'h00, 5'd4, 0, 1, 2, 32'd0, 32'h0000_0003, 0));
        tick();
        idle();
        #1;
        checks++;
        if ({bus.alu_op_code, bus.alu_operand1, bus.alu_operand2, bus.ex_dest} !==
            {4'd0, 32'd3, 32'd4, 5'd2}) begin
            failures++;
            $display("FAIL sll got op=%0d op1=%h op2=%h dest=%0d expected 0/3/4/2",
                     bus.alu_op_code, bus.alu_operand1, bus.alu_operand2, bus.ex_dest);
        end
        drive(mk(1, 6'h0F, 6'h00, 0, 0, 2, 0, 32'd0, 32'd0, 16'h1234));
        tick();
        idle();
        #1;
        checks++;
        if ({bus.alu_op_code, bus.alu_operand1, bus.alu_operand2, bus.ex_dest} !==
            {4'd0, 32'h1234, 32'd16, 5'd2}) begin
            failures++;
            $display("FAIL lui got op=%0d op1=%h op2=%h dest=%0d expected 0/1234/10/2",
                     bus.alu_op_code, bus.alu_operand1, bus.alu_operand2, bus.ex_dest);
        end
        drive(mk(1, 6'h08, 6'h00, 0, 0, 6, 0, 32'd0, 32'd0, 16'hFFFF));
        tick();
        drive(mk(1, 6'h0C, 6'h00, 0, 0, 6, 0, 32'd0, 32'd0, 16'hFFFF));
        #1;
        checks++;
        if (bus.alu_operand2 !== 32'hFFFF_FFFF) begin
            failures++;
            $display("FAIL addi_sext got op2=%h expected ffffffff", bus.alu_operand2);
        end
        tick();
        idle();
        #1;
        checks++;
        if (bus.alu_operand2 !== 32'h0000_FFFF || bus.alu_op_code !== 4'd5) begin
            failures++;
            $display("FAIL andi_zext got op2=%h op=%0d expected 0000ffff/5", bus.alu_operand2, bus.alu_op_code);
        end
    endtask

    task automatic test_flush_stall();
        drive(mk(1, 6'h00, 6'h20, 0, 1, 2, 3, 32'd5, 32'd7, 0));
        tick();
        drive(mk(1, 6'h00, 6'h22, 0, 8, 9, 10, 32'd1, 32'd1, 0));
        bus.flush_i = 1; bus.stall_i = 1;
        tick();
        idle();
        #1;
        checks++;
        if ({bus.ex_valid, bus.ex_reg_write, bus.alu_op_code} !== 6'd0) begin
            failures++;
            $display("FAIL flush_stall got valid=%b rw=%b op=%0d expected 0/0/0",
                     bus.ex_valid, bus.ex_reg_write, bus.alu_op_code);
        end
        drive(mk(1, 6'h00, 6'h20, 0, 1, 2, 3, 32'd5, 32'd7, 0));
        tick();
        drive(mk(1, 6'h00, 6'h22, 0, 8, 9, 10, 32'd1, 32'd1, 0));
        bus.stall_i = 1;
        for (int c = 0; c < 3; c++) begin
            tick();
            checks++;
            if ({bus.ex_valid, bus.alu_op_code, bus.ex_dest, bus.ex_reg_write,
                 bus.alu_operand1, bus.alu_operand2} !== {1'b1, 4'd3, 5'd3, 1'b1, 32'd5, 32'd7}) begin
                failures++;
                $display("FAIL stall_hold cycle=%0d got valid=%b op=%0d dest=%0d op1=%0d op2=%0d expected 1/3/3/5/7",
                         c, bus.ex_valid, bus.alu_op_code, bus.ex_dest, bus.alu_operand1, bus.alu_operand2);
            end
        end
        bus.stall_i = 0;
        tick();
        idle();
        #1;
        checks++;
        if ({bus.alu_op_code, bus.ex_dest} !== {4'd4, 5'd10}) begin
            failures++;
            $display("FAIL stall_release got op=%0d dest=%0d expected 4/10", bus.alu_op_code, bus.ex_dest);
        end
    endtask

    task automatic test_reset_midstream();
        drive(mk(1, 6'h23, 6'h00, 0, 1, 4, 0, 32'd10, 32'd3, 16'd8));
        tick();
        idle();
        #1;
        checks++;
        if (bus.ex_valid !== 1'b1) begin
            failures++;
            $display("FAIL midreset_pre got valid=%b expected 1", bus.ex_valid);
        end
        rst_n = 0;
        #1;
        checks++;
        if ({bus.ex_valid, bus.alu_op_code, bus.ex_dest, bus.ex_reg_write, bus.ex_mem_read,
             bus.ex_mem_to_reg, bus.alu_operand1, bus.alu_operand2} !== 77'd0) begin
            failures++;
            $display("FAIL midreset got valid=%b op=%0d dest=%0d mr=%b op1=%h op2=%h expected all 0",
                     bus.ex_valid, bus.alu_op_code, bus.ex_dest, bus.ex_mem_read,
                     bus.alu_operand1, bus.alu_operand2);
        end
        tick();
        rst_n = 1;
        tick();
    endtask

    task automatic test_random();
        instr_t cur;
        exp_t   x;
        logic   lu;
        logic [11:0] sel;
        idle();
        bus.flush_i = 1;
        tick();
        ex_model = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(0, 9) == 0) sel = BAD_OPS[$urandom_range(0, 2)];
            else                           sel = OPS[$urandom_range(0, 23)];
            cur = mk($urandom_range(0, 99) < 85, sel[11:6], sel[5:0], 5'($urandom),
                     5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                     $urandom, $urandom, 16'($urandom));
            drive(cur);
            bus.stall_i = ($urandom_range(0, 9) == 0);
            bus.flush_i = ($urandom_range(0, 11) == 0);
            bus.exmem_reg_write = 1'($urandom); bus.exmem_rd = 5'($urandom_range(0, 7));
            bus.exmem_result = $urandom;
            bus.memwb_reg_write = 1'($urandom); bus.memwb_rd = 5'($urandom_range(0, 7));
            bus.memwb_result = $urandom;
            #1;
            x  = model(ex_model);
            lu = m_load_use();
            checks++;
            if ({bus.ex_valid, bus.alu_op_code, bus.ex_dest, bus.ex_reg_write, bus.ex_mem_read,
                 bus.ex_mem_write, bus.ex_mem_to_reg} !==
                {x.valid, x.op, x.dest, x.rw, x.mr, x.mw, x.m2r}) begin
                failures++;
                $display("FAIL rand_ctrl cyc=%0d got v=%b op=%0d d=%0d rw%b mr%b mw%b m2r%b expected v=%b op=%0d d=%0d rw%b mr%b mw%b m2r%b",
                         c, bus.ex_valid, bus.alu_op_code, bus.ex_dest, bus.ex_reg_write,
                         bus.ex_mem_read, bus.ex_mem_write, bus.ex_mem_to_reg,
                         x.valid, x.op, x.dest, x.rw, x.mr, x.mw, x.m2r);
            end
            checks++;
            if (bus.alu_operand1 !== x.op1 || bus.alu_operand2 !== x.op2 || bus.ex_store_data !== x.store) begin
                failures++;
                $display("FAIL rand_data cyc=%0d got op1=%h op2=%h st=%h expected op1=%h op2=%h st=%h",
                         c, bus.alu_operand1, bus.alu_operand2, bus.ex_store_data, x.op1, x.op2, x.store);
            end
            checks++;
            if (bus.load_use_o !== lu) begin
                failures++;
                $display("FAIL rand_load_use cyc=%0d got %b expected %b", c, bus.load_use_o, lu);
            end
            if (bus.flush_i)       ex_model = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
            else if (bus.stall_i)  ex_model = ex_model;
            else if (lu)           ex_model = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
            else                   ex_model = cur;
            tick();
        end
        idle();
    endtask

    initial begin
        test_reset();
        test_add();
        test_forward();
        test_load_use();
        test_shift_lui();
        test_flush_stall();
        test_reset_midstream();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
